// File: rtl/ysyx_24070017_pkg.sv
// Shared register-file constants and the architectural word type for the NPC core.
package ysyx_24070017_pkg;
  localparam int WORD_LENGTH = 32;
  localparam int REG_NUM     = 32;
  localparam int AW          = $clog2(REG_NUM);

  typedef logic [WORD_LENGTH-1:0] word_t;
endpackage

// File: rtl/ysyx_24070017_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by issue, cleared by writeback, wiped by flush.
// Lookup is combinational; a same-cycle writeback to the looked-up register hides its busy bit when bypassing.
module ysyx_24070017_rf_scoreboard #(
  parameter int REG_NUM = ysyx_24070017_pkg::REG_NUM,
  parameter int NR      = 2,
  parameter int NW      = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NR*AW-1:0] raddr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [NR-1:0]    rbusy
);
  import ysyx_24070017_pkg::*;

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;

  // Clears first, then the set, so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NW; k++) begin
      if (we[k] && waddr[k*AW +: AW] != '0) busy_nxt[waddr[k*AW +: AW]] = 1'b0;
    end
    if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_comb begin
    logic hit;
    rbusy = '0;
    for (int j = 0; j < NR; j++) begin
      hit = 1'b0;
      for (int k = 0; k < NW; k++) begin
        if (we[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW]) hit = 1'b1;
      end
      rbusy[j] = busy[raddr[j*AW +: AW]] & ~((BYPASS != 0) && hit);
    end
  end
endmodule

// File: rtl/ysyx_24070017_regfile_mp.sv
// Multi-port integer register file (x0 hardwired to zero) with optional write-to-read bypass
// and an attached busy scoreboard for RAW hazard detection at issue.
module ysyx_24070017_regfile_mp #(
  parameter int WORD_LENGTH             = ysyx_24070017_pkg::WORD_LENGTH,
  parameter int REG_NUM                 = ysyx_24070017_pkg::REG_NUM,
  parameter int NR                      = 2,
  parameter int NW                      = 1,
  parameter int BYPASS                  = 1,
  parameter logic [WORD_LENGTH-1:0] RESET_VAL = '0,
  localparam int AW                     = $clog2(REG_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NW-1:0]                  we,
  input  logic [NW*AW-1:0]               waddr,
  input  logic [NW*WORD_LENGTH-1:0]      wdata,
  input  logic [NR*AW-1:0]               raddr,
  output logic [NR*WORD_LENGTH-1:0]      rdata,
  output logic [NR-1:0]                  rbusy,
  input  logic                           iss_valid,
  input  logic [AW-1:0]                  iss_rd,
  input  logic                           flush,
  output logic [REG_NUM*WORD_LENGTH-1:0] dbg_regs
);
  import ysyx_24070017_pkg::*;

  logic [WORD_LENGTH-1:0] regs [REG_NUM];
  logic [REG_NUM-1:0]     wsel [NW];

  // One-hot target per write port; x0 never selected.
  for (genvar k = 0; k < NW; k++) begin : g_wport
    assign wsel[k] = (we[k] && waddr[k*AW +: AW] != '0) ?
                     (REG_NUM'(1) << waddr[k*AW +: AW]) : '0;
  end

  // Ports are applied in ascending order, so the highest index lands last and wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs[0] <= '0;
      for (int i = 1; i < REG_NUM; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int k = 0; k < NW; k++) begin
        for (int i = 1; i < REG_NUM; i++) begin
          if (wsel[k][i]) regs[i] <= wdata[k*WORD_LENGTH +: WORD_LENGTH];
        end
      end
    end
  end

  always_comb begin
    logic [WORD_LENGTH-1:0] v;
    rdata = '0;
    for (int j = 0; j < NR; j++) begin
      v = regs[raddr[j*AW +: AW]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (we[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW]) v = wdata[k*WORD_LENGTH +: WORD_LENGTH];
        end
      end
      if (raddr[j*AW +: AW] == '0) v = '0;
      rdata[j*WORD_LENGTH +: WORD_LENGTH] = v;
    end
  end

  for (genvar i = 0; i < REG_NUM; i++) begin : g_dbg
    if (i == 0) begin : g_zero
      assign dbg_regs[i*WORD_LENGTH +: WORD_LENGTH] = '0;
    end else begin : g_reg
      assign dbg_regs[i*WORD_LENGTH +: WORD_LENGTH] = regs[i];
    end
  end

  ysyx_24070017_rf_scoreboard #(
    .REG_NUM (REG_NUM),
    .NR      (NR),
    .NW      (NW),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .raddr     (raddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .rbusy     (rbusy)
  );
endmodule

// File: tb/tb_ysyx_24070017_regfile_mp.sv
// Directed bench for the register file: reset, bypass, write priority, x0, scoreboard set/clear/flush.
module tb_ysyx_24070017_regfile_mp;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam logic [31:0] RV = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    we;
  logic [9:0]    waddr;
  logic [63:0]   wdata;
  logic [9:0]    raddr;
  logic [63:0]   rdata;
  logic [1:0]    rbusy;
  logic          iss_valid;
  logic [4:0]    iss_rd;
  logic          flush;
  logic [1023:0] dbg_regs;

  int n_cmp  = 0;
  int n_fail = 0;

  ysyx_24070017_regfile_mp #(
    .WORD_LENGTH (32),
    .REG_NUM     (32),
    .NR          (2),
    .NW          (2),
    .BYPASS      (1),
    .RESET_VAL   (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .dbg_regs  (dbg_regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*W +: W] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rport(input int p);
    return rdata[p*W +: W];
  endfunction

  function automatic logic [31:0] dbg(input int i);
    return dbg_regs[i*W +: W];
  endfunction

  initial begin
    idle();
    raddr = '0;
    // Reset held two cycles while a write and an issue are requested
    rst = 1'b0;
    wr(0, 5'd5, 32'h99);
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick(); tick();
    rst = 1'b1; idle();
    rd(0, 5'd5); rd(1, 5'd0);
    #1;
    check("rst_rdata_x5", rport(0), RV);
    check("rst_rdata_x0", rport(1), 32'h0);
    check("rst_rbusy", {30'b0, rbusy}, 32'h0);
    check("rst_dbg_x31", dbg(31), RV);
    check("rst_dbg_x0", dbg(0), 32'h0);

    // Same-cycle bypass, registered state unaffected until the edge
    wr(0, 5'd3, 32'hDEAD_BEEF); rd(0, 5'd3);
    #1;
    check("byp_rdata_x3", rport(0), 32'hDEAD_BEEF);
    check("byp_dbg_x3_old", dbg(3), RV);
    tick(); idle();
    #1;
    check("wr_rdata_x3", rport(0), 32'hDEAD_BEEF);
    check("wr_dbg_x3", dbg(3), 32'hDEAD_BEEF);

    // Both ports to x7: port 1 wins, both bypassed and committed
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7);
    #1;
    check("prio_byp_x7", rport(0), 32'h22);
    tick(); idle();
    #1;
    check("prio_wr_x7", rport(0), 32'h22);
    // Distinct addresses on the two ports both commit
    wr(0, 5'd10, 32'hA); wr(1, 5'd11, 32'hB);
    tick(); idle(); rd(0, 5'd10); rd(1, 5'd11);
    #1;
    check("dual_x10", rport(0), 32'hA);
    check("dual_x11", rport(1), 32'hB);
    // x0 write discarded, also on the bypass path
    wr(0, 5'd0, 32'hFFFF); rd(0, 5'd0);
    #1;
    check("x0_byp", rport(0), 32'h0);
    tick(); idle();
    #1;
    check("x0_read", rport(0), 32'h0);
    check("x0_dbg", dbg(0), 32'h0);

    // Issue marks x9 busy only from the next cycle
    iss_valid = 1'b1; iss_rd = 5'd9; rd(1, 5'd9);
    #1;
    check("iss_same_cycle", {31'b0, rbusy[1]}, 32'h0);
    tick(); idle();
    #1;
    check("iss_busy_x9", {31'b0, rbusy[1]}, 32'h1);
    // Writeback plus reissue of x9: set beats clear; bypass hides busy this cycle
    wr(0, 5'd9, 32'h5); iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    check("wb_byp_rbusy", {31'b0, rbusy[1]}, 32'h0);
    check("wb_byp_rdata", rport(1), 32'h5);
    tick(); idle();
    #1;
    check("set_wins_busy", {31'b0, rbusy[1]}, 32'h1);
    check("set_wins_data", rport(1), 32'h5);
    wr(1, 5'd9, 32'h6);
    tick(); idle();
    #1;
    check("clear_busy_x9", {31'b0, rbusy[1]}, 32'h0);
    check("clear_data_x9", rport(1), 32'h6);

    // Flush wipes busy, ignores the concurrent issue, keeps the write
    iss_valid = 1'b1; iss_rd = 5'd4; tick();
    iss_rd = 5'd6; tick(); idle();
    rd(0, 5'd4); rd(1, 5'd6);
    #1;
    check("busy_x4_x6", {30'b0, rbusy}, 32'h3);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8; wr(0, 5'd12, 32'h77);
    tick(); idle();
    #1;
    check("flush_x4_x6", {30'b0, rbusy}, 32'h0);
    rd(0, 5'd8); rd(1, 5'd12);
    #1;
    check("flush_x8", {31'b0, rbusy[0]}, 32'h0);
    check("flush_wr_x12", rport(1), 32'h77);

    // Reset dominates a concurrent write and issue
    wr(0, 5'd2, 32'h1); iss_valid = 1'b1; iss_rd = 5'd2; tick(); idle();
    rd(0, 5'd2);
    #1;
    check("pre_rst_busy_x2", {31'b0, rbusy[0]}, 32'h1);
    rst = 1'b0; wr(0, 5'd2, 32'hAA); iss_valid = 1'b1; iss_rd = 5'd2;
    tick(); rst = 1'b1; idle();
    #1;
    check("rst_dom_busy", {31'b0, rbusy[0]}, 32'h0);
    check("rst_dom_x2", rport(0), RV);
    check("rst_dom_x12", dbg(12), RV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
